// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative multiply/divide unit that owns the HI/LO registers.
//   MULT/MULTU : shift-add, one multiplier bit per enabled edge, {hi,lo} = product.
//   DIV/DIVU   : restoring shift-subtract, lo = quotient, hi = remainder.
//   MTHI/MTLO  : single-cycle write of operand a into hi/lo (only while idle).
// Ports:
//   clk, reset (async, active-high), clk_enable (global hold when low)
//   start, op[2:0], a, b  : issue strobe, opcode and operands from execute
//   busy                  : mul/div in flight (WIDTH+1 enabled cycles)
//   done                  : one enabled-cycle pulse after HI/LO commit
//   div_zero              : sticky, divisor of the last DIV/DIVU was zero
//   hi, lo                : architectural HI/LO registers
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Shared work register: MUL {partial product (W+1), multiplier (W)},
  // DIV {remainder (W+1), dividend/quotient (W)}.
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;   // product / quotient sign
  logic               rneg_q, rneg_d;   // remainder sign (dividend sign)
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_signed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH:0]   mul_next, div_next;
  logic [2*WIDTH-1:0] prod_fix;

  // Magnitude of a value; the most negative number maps to 2^(W-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negw(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Iteration datapath
  always_comb begin
    is_signed = ~op[0];
    mul_sum   = work_q[2*WIDTH:WIDTH] + {1'b0, (work_q[0] ? opnd_q : '0)};
    mul_next  = {1'b0, mul_sum, work_q[WIDTH-1:1]};
    rem_sh    = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    trial     = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (trial[WIDTH+1])
      div_next = {rem_sh, work_q[WIDTH-2:0], 1'b0};
    else
      div_next = {trial[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
    prod_fix  = neg2w(work_q[2*WIDTH-1:0], qneg_q);
  end

  // Next-state / control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            3'b000, 3'b001: begin
              opnd_d   = mag(a, is_signed);
              work_d   = {{(WIDTH+1){1'b0}}, mag(b, is_signed)};
              qneg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              is_div_d = 1'b0;
              cnt_d    = CW'(WIDTH-1);
              state_d  = S_MUL;
            end
            3'b010, 3'b011: begin
              opnd_d   = mag(b, is_signed);
              work_d   = {{(WIDTH+1){1'b0}}, mag(a, is_signed)};
              qneg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d   = is_signed & a[WIDTH-1];
              dz_d     = (b == '0);
              is_div_d = 1'b1;
              cnt_d    = CW'(WIDTH-1);
              state_d  = S_DIV;
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        work_d = (state_q == S_MUL) ? mul_next : div_next;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (is_div_q) begin
          // A zero divisor leaves the remainder equal to |a|, so sign
          // correction restores a exactly; only the quotient is forced.
          lo_d = dz_q ? '1 : negw(work_q[WIDTH-1:0], qneg_q);
          hi_d = negw(work_q[2*WIDTH-1:WIDTH], rneg_q);
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
